// File: rtl/reg_writeback_unit_if.sv
// reg_writeback_unit_if: ALU/load/writeback bus between pipeline and the writeback unit
interface reg_writeback_unit_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic ALU_VALID;
  logic [ADDR_W-1:0] ALU_RD;
  logic [DATA_W-1:0] ALU_DATA;
  logic LD_ISSUE;
  logic [ADDR_W-1:0] LD_RD;
  logic ISSUE_READY;
  logic LD_RESP_VALID;
  logic [DATA_W-1:0] LD_RESP_DATA;
  logic WB_WRITE;
  logic [ADDR_W-1:0] WB_ADDR;
  logic [DATA_W-1:0] WB_DATA;
  logic [31:0] PENDING;
  logic PROT_ERR;
  modport master(
    output ALU_VALID, ALU_RD, ALU_DATA, LD_ISSUE, LD_RD, LD_RESP_VALID, LD_RESP_DATA,
    input ISSUE_READY, WB_WRITE, WB_ADDR, WB_DATA, PENDING, PROT_ERR
  );
  modport slave(
    input ALU_VALID, ALU_RD, ALU_DATA, LD_ISSUE, LD_RD, LD_RESP_VALID, LD_RESP_DATA,
    output ISSUE_READY, WB_WRITE, WB_ADDR, WB_DATA, PENDING, PROT_ERR
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: merges ALU results and in-order load responses onto the register-file write port
module reg_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic CLK,
  input logic RESET,
  reg_writeback_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] tq_rd [DEPTH];
  logic [ADDR_W-1:0] dq_rd [DEPTH];
  logic [DATA_W-1:0] dq_data [DEPTH];
  logic [PW-1:0] tq_wp, tq_rp, dq_wp, dq_rp;
  logic [PW:0] tq_cnt, dq_cnt;
  logic issue_ready, push_tag, resp_ok, push_data, alu_wr, pop_data;
  logic [31:0] pend;
  assign issue_ready = tq_cnt + dq_cnt < (PW+1)'(DEPTH);
  assign push_tag = bus.LD_ISSUE && issue_ready;
  assign resp_ok = bus.LD_RESP_VALID && tq_cnt != '0;
  assign push_data = resp_ok && tq_rd[tq_rp] != '0;
  assign alu_wr = bus.ALU_VALID && bus.ALU_RD != '0;
  assign pop_data = !alu_wr && dq_cnt != '0;
  assign bus.ISSUE_READY = issue_ready;
  assign bus.PENDING = pend;
  // A slot is live when its distance from the read pointer is below the occupancy
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - tq_rp} < tq_cnt) pend[tq_rd[i]] = 1'b1;
      if ({1'b0, PW'(i) - dq_rp} < dq_cnt) pend[dq_rd[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end
  always_ff @(posedge CLK) begin
    if (push_tag) tq_rd[tq_wp] <= bus.LD_RD;
    if (push_data) begin
      dq_rd[dq_wp] <= tq_rd[tq_rp];
      dq_data[dq_wp] <= bus.LD_RESP_DATA;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tq_wp <= '0;
      tq_rp <= '0;
      dq_wp <= '0;
      dq_rp <= '0;
      tq_cnt <= '0;
      dq_cnt <= '0;
      bus.WB_WRITE <= 1'b0;
      bus.WB_ADDR <= '0;
      bus.WB_DATA <= '0;
      bus.PROT_ERR <= 1'b0;
    end else begin
      if (push_tag) tq_wp <= tq_wp + 1'b1;
      if (resp_ok) tq_rp <= tq_rp + 1'b1;
      if (push_data) dq_wp <= dq_wp + 1'b1;
      if (pop_data) dq_rp <= dq_rp + 1'b1;
      tq_cnt <= tq_cnt + (PW+1)'(push_tag) - (PW+1)'(resp_ok);
      dq_cnt <= dq_cnt + (PW+1)'(push_data) - (PW+1)'(pop_data);
      bus.WB_WRITE <= alu_wr || pop_data;
      if (alu_wr) begin
        bus.WB_ADDR <= bus.ALU_RD;
        bus.WB_DATA <= bus.ALU_DATA;
      end else if (pop_data) begin
        bus.WB_ADDR <= dq_rd[dq_rp];
        bus.WB_DATA <= dq_data[dq_rp];
      end
      bus.PROT_ERR <= bus.PROT_ERR || (bus.LD_ISSUE && !issue_ready) ||
                      (bus.LD_RESP_VALID && tq_cnt == '0) || (alu_wr && pend[bus.ALU_RD]);
    end
  end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed vectors with hand-computed expectations for reg_writeback_unit
module tb_reg_writeback_unit;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  reg_writeback_unit_if #(.DATA_W(32), .ADDR_W(5)) bus();
  reg_writeback_unit #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (.CLK(CLK), .RESET(RESET), .bus(bus.slave));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic pulse_reset();
    #2 RESET = 1'b1;
    #2 RESET = 1'b0;
  endtask
  task automatic wb(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".write"}, 32'(bus.WB_WRITE), 32'(w));
    if (w) begin
      check({tag, ".addr"}, 32'(bus.WB_ADDR), 32'(a));
      check({tag, ".data"}, bus.WB_DATA, d);
    end
  endtask
  task automatic issue(input logic [4:0] rd);
    bus.LD_ISSUE = 1'b1;
    bus.LD_RD = rd;
    tick();
    bus.LD_ISSUE = 1'b0;
  endtask
  initial begin
    logic [4:0] rds [4];
    logic [31:0] dats [4];
    rds = '{5'd3, 5'd4, 5'd6, 5'd7};
    dats = '{32'd10, 32'd20, 32'd30, 32'd40};
    bus.ALU_VALID = 1'b0;
    bus.ALU_RD = '0;
    bus.ALU_DATA = '0;
    bus.LD_ISSUE = 1'b0;
    bus.LD_RD = '0;
    bus.LD_RESP_VALID = 1'b0;
    bus.LD_RESP_DATA = '0;
    #12;
    check("rst.write", 32'(bus.WB_WRITE), 32'd0);
    check("rst.addr", 32'(bus.WB_ADDR), 32'd0);
    check("rst.data", bus.WB_DATA, 32'd0);
    check("rst.pending", bus.PENDING, 32'd0);
    check("rst.prot", 32'(bus.PROT_ERR), 32'd0);
    check("rst.ready", 32'(bus.ISSUE_READY), 32'd1);
    RESET = 1'b0;
    tick();
    bus.ALU_VALID = 1'b1;
    bus.ALU_RD = 5'd5;
    bus.ALU_DATA = 32'd95;
    tick();
    bus.ALU_VALID = 1'b0;
    wb("alu", 1'b1, 5'd5, 32'd95);
    tick();
    wb("alu.idle", 1'b0, 5'd0, 32'd0);
    check("alu.hold_addr", 32'(bus.WB_ADDR), 32'd5);
    check("alu.prot", 32'(bus.PROT_ERR), 32'd0);
    issue(5'd2);
    check("ld.pending", bus.PENDING, 32'h4);
    tick();
    tick();
    bus.LD_RESP_VALID = 1'b1;
    bus.LD_RESP_DATA = 32'd28;
    tick();
    bus.LD_RESP_VALID = 1'b0;
    wb("ld.buffered", 1'b0, 5'd0, 32'd0);
    check("ld.pending_buf", bus.PENDING, 32'h4);
    tick();
    wb("ld", 1'b1, 5'd2, 32'd28);
    check("ld.pending_clr", bus.PENDING, 32'h0);
    for (int k = 0; k < 4; k++) issue(rds[k]);
    check("full.ready", 32'(bus.ISSUE_READY), 32'd0);
    check("full.pending", bus.PENDING, 32'hd8);
    issue(5'd9);
    check("full.prot", 32'(bus.PROT_ERR), 32'd1);
    check("full.ignored", bus.PENDING, 32'hd8);
    for (int k = 0; k < 4; k++) begin
      bus.LD_RESP_VALID = 1'b1;
      bus.LD_RESP_DATA = dats[k];
      tick();
      if (k == 0) wb("full.first", 1'b0, 5'd0, 32'd0);
      else wb($sformatf("full.wb%0d", k - 1), 1'b1, rds[k-1], dats[k-1]);
    end
    bus.LD_RESP_VALID = 1'b0;
    tick();
    wb("full.wb3", 1'b1, 5'd7, 32'd40);
    check("full.drained", bus.PENDING, 32'h0);
    check("full.ready2", 32'(bus.ISSUE_READY), 32'd1);
    pulse_reset();
    check("rst2.prot", 32'(bus.PROT_ERR), 32'd0);
    issue(5'd1);
    bus.LD_RESP_VALID = 1'b1;
    bus.LD_RESP_DATA = 32'd50;
    bus.ALU_VALID = 1'b1;
    bus.ALU_RD = 5'd8;
    bus.ALU_DATA = 32'd15;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.LD_RESP_VALID = 1'b0;
      wb($sformatf("starve.alu%0d", k), 1'b1, 5'd8, 32'd15);
      check($sformatf("starve.pend%0d", k), bus.PENDING, 32'h2);
    end
    bus.ALU_VALID = 1'b0;
    tick();
    wb("starve.ld", 1'b1, 5'd1, 32'd50);
    check("starve.pend_clr", bus.PENDING, 32'h0);
    check("starve.prot", 32'(bus.PROT_ERR), 32'd0);
    issue(5'd12);
    bus.ALU_VALID = 1'b1;
    bus.ALU_RD = 5'd12;
    bus.ALU_DATA = 32'd7;
    tick();
    bus.ALU_VALID = 1'b0;
    wb("waw.alu", 1'b1, 5'd12, 32'd7);
    check("waw.prot", 32'(bus.PROT_ERR), 32'd1);
    bus.LD_RESP_VALID = 1'b1;
    bus.LD_RESP_DATA = 32'd33;
    tick();
    bus.LD_RESP_VALID = 1'b0;
    tick();
    wb("waw.ld", 1'b1, 5'd12, 32'd33);
    pulse_reset();
    issue(5'd0);
    check("x0.pending", bus.PENDING, 32'h0);
    bus.LD_RESP_VALID = 1'b1;
    bus.LD_RESP_DATA = 32'd99;
    tick();
    bus.LD_RESP_VALID = 1'b0;
    wb("x0.drop0", 1'b0, 5'd0, 32'd0);
    tick();
    wb("x0.drop1", 1'b0, 5'd0, 32'd0);
    bus.ALU_VALID = 1'b1;
    bus.ALU_RD = 5'd0;
    bus.ALU_DATA = 32'd123;
    tick();
    bus.ALU_VALID = 1'b0;
    wb("x0.alu", 1'b0, 5'd0, 32'd0);
    check("x0.prot", 32'(bus.PROT_ERR), 32'd0);
    issue(5'd3);
    issue(5'd4);
    check("arst.pre", bus.PENDING, 32'h18);
    #2 RESET = 1'b1;
    #1;
    check("arst.write", 32'(bus.WB_WRITE), 32'd0);
    check("arst.addr", 32'(bus.WB_ADDR), 32'd0);
    check("arst.data", bus.WB_DATA, 32'd0);
    check("arst.pending", bus.PENDING, 32'd0);
    check("arst.ready", 32'(bus.ISSUE_READY), 32'd1);
    #1 RESET = 1'b0;
    bus.LD_RESP_VALID = 1'b1;
    bus.LD_RESP_DATA = 32'd77;
    bus.LD_ISSUE = 1'b1;
    bus.LD_RD = 5'd5;
    tick();
    bus.LD_RESP_VALID = 1'b0;
    bus.LD_ISSUE = 1'b0;
    check("orphan.prot", 32'(bus.PROT_ERR), 32'd1);
    check("orphan.pending", bus.PENDING, 32'h20);
    wb("orphan.nowrite", 1'b0, 5'd0, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
